// File: rtl/rename_reg_file_if.sv
// Bundle between dispatch, the instruction buffer, retirement and the rename register file.
// master drives reads, allocations, retires and flush; slave returns the registered read results.
interface rename_reg_file_if #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter int TAG_W     = 4,
  parameter int NUM_RD    = 8,
  parameter int NUM_WR    = 3,
  parameter int NUM_ALLOC = 2
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int RW = DATA_W + 1 + TAG_W;

  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*AW-1:0]       rd_addr;
  logic [NUM_RD*RW-1:0]       rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic [NUM_ALLOC-1:0]       alloc_en;
  logic [NUM_ALLOC*AW-1:0]    alloc_addr;
  logic [NUM_ALLOC*TAG_W-1:0] alloc_tag;
  logic [NUM_WR-1:0]          ret_en;
  logic [NUM_WR*AW-1:0]       ret_addr;
  logic [NUM_WR*TAG_W-1:0]    ret_tag;
  logic [NUM_WR*DATA_W-1:0]   ret_data;
  logic                       flush;

  modport master (
    output rd_en, rd_addr, alloc_en, alloc_addr, alloc_tag,
    output ret_en, ret_addr, ret_tag, ret_data, flush,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, alloc_en, alloc_addr, alloc_tag,
    input  ret_en, ret_addr, ret_tag, ret_data, flush,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register busy bit and owner tag.
// Ports: clk, rst (sync, active high), bus (slave: reads, allocs, retires, flush).
module rename_reg_file #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter int TAG_W     = 4,
  parameter int NUM_RD    = 8,
  parameter int NUM_WR    = 3,
  parameter int NUM_ALLOC = 2
) (
  input logic clk,
  input logic rst,
  rename_reg_file_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int RW = DATA_W + 1 + TAG_W;

  logic [DATA_W-1:0]   val_q [NUM_REGS];
  logic [DATA_W-1:0]   val_d [NUM_REGS];
  logic [TAG_W-1:0]    own_q [NUM_REGS];
  logic [TAG_W-1:0]    own_d [NUM_REGS];
  logic [TAG_W-1:0]    rd_own [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] rd_busy;
  logic [NUM_REGS-1:0] rel;

  // Retire: later lanes overwrite earlier ones; release compares
  // against the owner held before this edge.
  always_comb begin
    val_d = val_q;
    rel   = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.ret_en[w]) begin
        val_d[bus.ret_addr[w*AW +: AW]] =
          bus.ret_data[w*DATA_W +: DATA_W];
        if (bus.ret_tag[w*TAG_W +: TAG_W] ==
            own_q[bus.ret_addr[w*AW +: AW]])
          rel[bus.ret_addr[w*AW +: AW]] = 1'b1;
      end
    end
  end

  // rd_busy/rd_own is the state reads see: release and flush applied,
  // allocations not yet.
  always_comb begin
    rd_busy = busy_q & ~rel;
    rd_own  = own_q;
    if (bus.flush) begin
      rd_busy = '0;
      for (int r = 0; r < NUM_REGS; r++)
        rd_own[r] = '0;
    end
    busy_d = rd_busy;
    own_d  = rd_own;
    if (!bus.flush) begin
      for (int a = 0; a < NUM_ALLOC; a++) begin
        if (bus.alloc_en[a]) begin
          busy_d[bus.alloc_addr[a*AW +: AW]] = 1'b1;
          own_d[bus.alloc_addr[a*AW +: AW]] =
            bus.alloc_tag[a*TAG_W +: TAG_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= '0;
        own_q[r] <= '0;
      end
      busy_q       <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= '0;
    end else begin
      val_q        <= val_d;
      own_q        <= own_d;
      busy_q       <= busy_d;
      bus.rd_valid <= bus.rd_en;
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.rd_en[i])
          bus.rd_data[i*RW +: RW] <= {
            val_d[bus.rd_addr[i*AW +: AW]],
            rd_busy[bus.rd_addr[i*AW +: AW]],
            rd_own[bus.rd_addr[i*AW +: AW]]
          };
      end
    end
  end
endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file.
// Drives #1 after each rising edge, checks #1 after the next.
module tb_rename_reg_file;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  rename_reg_file_if bus ();

  rename_reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    bus.alloc_en   = '0;
    bus.alloc_addr = '0;
    bus.alloc_tag  = '0;
    bus.ret_en     = '0;
    bus.ret_addr   = '0;
    bus.ret_tag    = '0;
    bus.ret_data   = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic rd(input int p, input logic [3:0] a);
    bus.rd_en[p]          = 1'b1;
    bus.rd_addr[p*4 +: 4] = a;
  endtask

  task automatic alloc(input int l, input logic [3:0] a,
                       input logic [3:0] t);
    bus.alloc_en[l]          = 1'b1;
    bus.alloc_addr[l*4 +: 4] = a;
    bus.alloc_tag[l*4 +: 4]  = t;
  endtask

  task automatic ret(input int l, input logic [3:0] a,
                     input logic [3:0] t, input logic [15:0] d);
    bus.ret_en[l]            = 1'b1;
    bus.ret_addr[l*4 +: 4]   = a;
    bus.ret_tag[l*4 +: 4]    = t;
    bus.ret_data[l*16 +: 16] = d;
  endtask

  function automatic logic [20:0] pd(input int p);
    return bus.rd_data[p*21 +: 21];
  endfunction

  task automatic rd_bank(input int base);
    for (int p = 0; p < 8; p++) rd(p, 4'(base + p));
  endtask

  function automatic logic [39:0] bo_all();
    logic [39:0] v;
    for (int p = 0; p < 8; p++) v[p*5 +: 5] = bus.rd_data[p*21 +: 5];
    return v;
  endfunction

  initial begin
    clr();
    rst = 1'b1;
    tick();
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_data", bus.rd_data, 0);
    rst = 1'b0;

    rd_bank(0);
    tick(); clr();
    chk("init_lo_valid", bus.rd_valid, 8'hFF);
    chk("init_lo_data", bus.rd_data, 0);
    rd_bank(8);
    tick(); clr();
    chk("init_hi_valid", bus.rd_valid, 8'hFF);
    chk("init_hi_data", bus.rd_data, 0);

    alloc(0, 4'd5, 4'h3);
    tick(); clr();
    rd(0, 4'd5);
    tick(); clr();
    chk("alloc_r5", pd(0), {16'h0000, 1'b1, 4'h3});

    ret(0, 4'd5, 4'h3, 16'hBEEF);
    rd(0, 4'd5);
    tick(); clr();
    chk("ret_byp_r5", pd(0), {16'hBEEF, 1'b0, 4'h3});
    rd(0, 4'd5);
    tick(); clr();
    chk("ret_after_r5", pd(0), {16'hBEEF, 1'b0, 4'h3});
    tick();
    chk("hold_valid", bus.rd_valid, 0);
    chk("hold_data", pd(0), {16'hBEEF, 1'b0, 4'h3});

    alloc(1, 4'd7, 4'h9);
    tick(); clr();
    ret(1, 4'd7, 4'h2, 16'h1234);
    rd(1, 4'd7);
    tick(); clr();
    chk("stale_byp_r7", pd(1), {16'h1234, 1'b1, 4'h9});
    rd(1, 4'd7);
    tick(); clr();
    chk("stale_r7", pd(1), {16'h1234, 1'b1, 4'h9});

    ret(0, 4'd1, 4'h0, 16'h0011);
    ret(2, 4'd1, 4'h0, 16'h0022);
    rd(2, 4'd1);
    tick(); clr();
    chk("ret_lane_r1", pd(2), {16'h0022, 1'b0, 4'h0});

    alloc(0, 4'd4, 4'h1);
    alloc(1, 4'd4, 4'h6);
    tick(); clr();
    rd(3, 4'd4);
    tick(); clr();
    chk("alloc_lane_r4", pd(3), {16'h0000, 1'b1, 4'h6});

    alloc(0, 4'd5, 4'h3);
    tick(); clr();
    alloc(1, 4'd5, 4'h8);
    ret(0, 4'd5, 4'h3, 16'h5555);
    rd(4, 4'd5);
    tick(); clr();
    chk("alloc_rel_byp", pd(4), {16'h5555, 1'b0, 4'h3});
    rd(4, 4'd5);
    tick(); clr();
    chk("alloc_over_rel", pd(4), {16'h5555, 1'b1, 4'h8});

    alloc(0, 4'd2, 4'hA);
    alloc(1, 4'd9, 4'hB);
    tick(); clr();
    bus.flush = 1'b1;
    alloc(0, 4'd3, 4'h5);
    ret(0, 4'd2, 4'h0, 16'hCAFE);
    rd(0, 4'd2);
    rd(1, 4'd3);
    tick(); clr();
    chk("flush_byp_r2", pd(0), {16'hCAFE, 1'b0, 4'h0});
    chk("flush_byp_r3", pd(1), 0);
    rd_bank(0);
    tick(); clr();
    chk("flush_bo_lo", bo_all(), 0);
    chk("flush_r2", pd(2), {16'hCAFE, 1'b0, 4'h0});
    chk("flush_r3", pd(3), 0);
    chk("flush_r7", pd(7), {16'h1234, 1'b0, 4'h0});
    rd_bank(8);
    tick(); clr();
    chk("flush_bo_hi", bo_all(), 0);

    rst = 1'b1;
    alloc(0, 4'd6, 4'h7);
    ret(0, 4'd1, 4'h0, 16'h9999);
    rd_bank(0);
    tick(); clr();
    chk("mid_rst_valid", bus.rd_valid, 0);
    chk("mid_rst_data", bus.rd_data, 0);
    rst = 1'b0;
    rd_bank(0);
    tick(); clr();
    chk("post_rst_valid", bus.rd_valid, 8'hFF);
    chk("post_rst_lo", bus.rd_data, 0);
    rd_bank(8);
    tick(); clr();
    chk("post_rst_hi", bus.rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
